// File: rtl/jailbreak_dip_loader.sv
// Host-side writer for the Jailbreak DIP word: stage, commit, timed core reset.
// Optional JAILBREAK_DIP_LIVE_UPDATE_EN lets flip/attract-sound changes skip the reset.
module jailbreak_dip_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic [17:0] dip_switch,
  output logic        core_reset_req,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } state_t;

  localparam logic [17:0] DIP_RESET = 18'h01600;
  localparam logic [15:0] CNT_LOAD  = 16'(HOLD_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [17:0] staged;
  logic [17:0] dip_n;
  logic        dropped, dropped_n;

  logic sel_stage, sel_commit, sel_stat;
  logic wr_stage, commit, clr_drop;
  logic differs, live_ok;
  logic unused_bits;

  assign sel_stage  = bridge_addr == BASE_ADDR;
  assign sel_commit = bridge_addr == BASE_ADDR + 32'd4;
  assign sel_stat   = bridge_addr == BASE_ADDR + 32'd8;

  assign wr_stage = bridge_wr && sel_stage;
  assign commit   = bridge_wr && sel_commit && bridge_wr_data[0];
  assign clr_drop = bridge_wr && sel_stat && bridge_wr_data[0];

  assign differs     = staged != dip_switch;
  assign unused_bits = ^bridge_wr_data[31:18];

`ifdef JAILBREAK_DIP_LIVE_UPDATE_EN
  localparam logic [17:0] LIVE_MASK = 18'h18000;
  // Flip and attract sound are safe to change under a running core.
  assign live_ok = ((staged ^ dip_switch) & ~LIVE_MASK) == '0;
`else
  assign live_ok = 1'b0;
`endif

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dip_switch <= DIP_RESET;
      dropped    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dip_switch <= dip_n;
      dropped    <= dropped_n;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    dip_n          = dip_switch;
    dropped_n      = dropped;
    core_reset_req = 1'b0;
    busy           = 1'b0;
    if (clr_drop) dropped_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit && differs) begin
          dip_n = staged;
          if (!live_ok) begin
            cnt_n   = CNT_LOAD;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        core_reset_req = 1'b1;
        busy           = 1'b1;
        if (commit) dropped_n = 1'b1;
        if (cnt == '0) state_n = RELEASE;
        else cnt_n = cnt - 16'd1;
      end
      RELEASE: begin
        busy    = 1'b1;
        state_n = IDLE;
        if (commit) dropped_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Reads sample pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      staged         <= DIP_RESET;
      bridge_rd_data <= '0;
    end else begin
      if (wr_stage) begin
        staged <= {bridge_wr_data[17:15], 1'b0, bridge_wr_data[13:0]};
      end
      if (bridge_rd) begin
        unique case (1'b1)
          sel_stage: bridge_rd_data <= {14'b0, staged};
          sel_stat:  bridge_rd_data <= {12'b0, dropped, busy, dip_switch};
          default:   bridge_rd_data <= '0;
        endcase
      end
    end
  end

endmodule

// File: doc/jailbreak_dip_loader.md
Name: jailbreak_dip_loader

Overview:
- Writer side of the Jailbreak DIP-switch word: turns host bridge writes into the 18-bit packed dip_switch_t consumed by the game core.
- Stages the host value, commits it on command, and requests a timed core reset whenever the active settings change.
- Sits between the APF bridge decode and the jailbreak core top, in the clk_74a domain.

Parameters:
- BASE_ADDR, 32'hF000_0000, byte address of the register block (3 words: +0 staged DIP, +4 commit, +8 status).
- HOLD_CYCLES, 1024, clk_74a cycles that core_reset_req is held after a committing change; legal range 1..65535.

Ports:
- clk_74a  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- bridge_addr  in  32  bridge byte address.
- bridge_wr  in  1  single-cycle write strobe.
- bridge_wr_data  in  32  write data.
- bridge_rd  in  1  single-cycle read strobe.
- bridge_rd_data  out  32  registered read data.
- dip_switch  out  18  active dip_switch_t value to the core.
- core_reset_req  out  1  high while the core must be held in reset.
- busy  out  1  high in HOLD or RELEASE.

Behaviour:
- Reset values: dip_switch = 18'h01600 (single controls, flip 0, attract 0, unused 0, difficulty normal, bonus 30k/70k, upright, 3 lives, 1C/1CR on both slots). staged = 18'h01600. core_reset_req = 0, busy = 0, bridge_rd_data = 0, commit_dropped = 0, FSM = IDLE.
- Write to BASE+0: staged <= bridge_wr_data[17:0] with bit 14 (unused) forced to 0. Accepted in every FSM state.
- Write to BASE+4 with data bit 0 = 1 is a commit request. Data bit 0 = 0 is ignored.
- Write to BASE+8 with data bit 0 = 1 clears commit_dropped.
- Writes to any other address are ignored.
- Read latency is 1 cycle. bridge_rd_data is updated only on the cycle after bridge_rd and holds its value otherwise.
  - BASE+0 returns {14'b0, staged}.
  - BASE+8 returns {12'b0, commit_dropped, busy, dip_switch}, i.e. bit 19 = commit_dropped, bit 18 = busy.
  - Any other address returns 32'h0.
- FSM states:
  - IDLE. On commit with staged != dip_switch: dip_switch <= staged, counter <= HOLD_CYCLES-1, go to HOLD. dip_switch updates on the same edge that asserts core_reset_req. On commit with staged == dip_switch: no action, stay in IDLE.
  - HOLD. core_reset_req = 1, busy = 1. Counter decrements each cycle. When counter == 0, go to RELEASE. core_reset_req is high for exactly HOLD_CYCLES cycles.
  - RELEASE. core_reset_req = 0, busy = 1 for exactly 1 cycle, then go to IDLE.
- Commit while busy: ignored and sets sticky commit_dropped. dip_switch must not change while busy.
- Simultaneous write to BASE+0 and commit cannot occur (single address per cycle). A commit uses the staged value registered on earlier cycles.
- Simultaneous bridge_rd and bridge_wr to the same address: the read returns the pre-write value.
- reset_n asserted mid-HOLD: all state returns to reset values immediately, and core_reset_req drops asynchronously.

Optional Feature:
- Macro: JAILBREAK_DIP_LIVE_UPDATE_EN.
- Defined: a commit whose staged value differs from dip_switch only in bit 16 (flip_screen) and/or bit 15 (attract_mode_sound) updates dip_switch in IDLE on the commit edge. No HOLD is entered, core_reset_req stays 0, busy stays 0.
- Not defined: every differing commit goes through HOLD/RELEASE.

Test Plan:
- Reset, then read BASE+8 -> bridge_rd_data = 32'h0000_1600 one cycle after bridge_rd. core_reset_req = 0.
- Write BASE+0 = 32'hFFFF_FFFF, read BASE+0 -> 32'h0003_BFFF (bit 14 cleared). dip_switch still 18'h01600.
- Stage 18'h01601, commit, HOLD_CYCLES = 4 -> dip_switch = 18'h01601 on the commit edge. core_reset_req high exactly 4 cycles, busy high exactly 5 cycles, then IDLE.
- During HOLD, stage 18'h01602 and commit -> dip_switch stays 18'h01601 and BASE+8 bit 19 = 1. Write BASE+8 = 1, then read BASE+8 -> bit 19 = 0.
- Commit with staged == dip_switch -> core_reset_req and busy stay 0. Then drop reset_n mid-HOLD of a real change -> core_reset_req = 0 and dip_switch = 18'h01600 without waiting for a clock edge.
- With JAILBREAK_DIP_LIVE_UPDATE_EN, stage 18'h11600 and commit -> dip_switch = 18'h11600, core_reset_req never asserted. Without the macro -> full HOLD of HOLD_CYCLES cycles.
